// File: rtl/aes_in_seq_if.sv
// Word stream into the AES load sequencer: 32-bit words over valid/ready,
// each tagged as key or text and, on the first word of a text block, with
// the cipher direction.
interface aes_in_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_kw;
  logic        in_mode;

  modport master (
    output in_valid,
    output in_data,
    output in_kw,
    output in_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_kw,
    input  in_mode,
    output in_ready
  );
endinterface

// File: rtl/aes_in_seq.sv
// AES upstream load sequencer. Collects four 32-bit words into a 128-bit key
// or text block, pulses kld/ld to the core, then waits for kdone/done under a
// timeout watchdog before accepting the next block. Reports protocol errors,
// text-without-key, timeouts, and counts completed text blocks.
module aes_in_seq #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  aes_in_seq_if.slave      in_if,
  output logic             kld,
  output logic [127:0]     key,
  output logic             ld,
  output logic [127:0]     text_in,
  output logic             mode,
  input  logic             kdone,
  input  logic             done,
  output logic             key_valid,
  output logic             busy,
  output logic             err_proto,
  output logic             err_nokey,
  output logic             err_tmo,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {StCollect, StKwait, StDwait} state_e;

  localparam logic [15:0] TmoLimit = 16'(TMO_CYCLES);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic               type_q, type_d;      // 1 = key block
  logic               mode_l_q, mode_l_d;  // mode captured on word 0 of a text block
  logic [95:0]        buf_q, buf_d;        // words 0..2; word 3 comes straight from the bus
  logic [127:0]       key_q, key_d;
  logic [127:0]       text_q, text_d;
  logic               mode_q, mode_d;
  logic               kld_q, kld_d;
  logic               ld_q, ld_d;
  logic               kv_q, kv_d;
  logic               err_proto_q, err_proto_d;
  logic               err_nokey_q, err_nokey_d;
  logic               err_tmo_q, err_tmo_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic               ready;
  logic               accept;
  logic [127:0]       blk;

  assign ready          = (state_q == StCollect) && !rst;
  assign accept         = in_if.in_valid && ready;
  assign blk            = {buf_q, in_if.in_data};
  assign in_if.in_ready = ready;

  // Next-state: word collection, load pulses, wait/timeout handling.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    type_d      = type_q;
    mode_l_d    = mode_l_q;
    buf_d       = buf_q;
    key_d       = key_q;
    text_d      = text_q;
    mode_d      = mode_q;
    kld_d       = 1'b0;
    ld_d        = 1'b0;
    kv_d        = kv_q;
    err_proto_d = 1'b0;
    err_nokey_d = 1'b0;
    err_tmo_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    blk_cnt_d   = blk_cnt_q;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if ((idx_q != 2'd0) && (in_if.in_kw != type_q)) begin
            // Type switched mid-block: drop the word and restart collection.
            idx_d       = 2'd0;
            err_proto_d = 1'b1;
          end else begin
            if (idx_q == 2'd0) begin
              type_d = in_if.in_kw;
              if (!in_if.in_kw) begin
                mode_l_d = in_if.in_mode;
              end
            end
            unique case (idx_q)
              2'd0: buf_d[95:64] = in_if.in_data;
              2'd1: buf_d[63:32] = in_if.in_data;
              2'd2: buf_d[31:0]  = in_if.in_data;
              2'd3: ;
              default: ;
            endcase
            if (idx_q == 2'd3) begin
              idx_d = 2'd0;
              if (type_q) begin
                key_d     = blk;
                kld_d     = 1'b1;
                kv_d      = 1'b0;
                tmo_cnt_d = '0;
                state_d   = StKwait;
              end else if (kv_q) begin
                text_d    = blk;
                mode_d    = mode_l_q;
                ld_d      = 1'b1;
                tmo_cnt_d = '0;
                state_d   = StDwait;
              end else begin
                err_nokey_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end

      StKwait: begin
        // kdone in the kld pulse cycle belongs to no request of ours.
        if (!kld_q && kdone) begin
          kv_d    = 1'b1;
          state_d = StCollect;
        end else if (tmo_cnt_q == TmoLimit) begin
          err_tmo_d = 1'b1;
          kv_d      = 1'b0;
          idx_d     = 2'd0;
          state_d   = StCollect;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      StDwait: begin
        if (!ld_q && done) begin
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = StCollect;
        end else if (tmo_cnt_q == TmoLimit) begin
          err_tmo_d = 1'b1;
          kv_d      = 1'b0;
          idx_d     = 2'd0;
          state_d   = StCollect;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StCollect;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State register with synchronous reset clearing every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      type_q      <= 1'b0;
      mode_l_q    <= 1'b0;
      buf_q       <= '0;
      key_q       <= '0;
      text_q      <= '0;
      mode_q      <= 1'b0;
      kld_q       <= 1'b0;
      ld_q        <= 1'b0;
      kv_q        <= 1'b0;
      err_proto_q <= 1'b0;
      err_nokey_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      mode_l_q    <= mode_l_d;
      buf_q       <= buf_d;
      key_q       <= key_d;
      text_q      <= text_d;
      mode_q      <= mode_d;
      kld_q       <= kld_d;
      ld_q        <= ld_d;
      kv_q        <= kv_d;
      err_proto_q <= err_proto_d;
      err_nokey_q <= err_nokey_d;
      err_tmo_q   <= err_tmo_d;
      tmo_cnt_q   <= tmo_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign kld       = kld_q;
  assign key       = key_q;
  assign ld        = ld_q;
  assign text_in   = text_q;
  assign mode      = mode_q;
  assign key_valid = kv_q;
  assign busy      = (state_q != StCollect);
  assign err_proto = err_proto_q;
  assign err_nokey = err_nokey_q;
  assign err_tmo   = err_tmo_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_in_seq.sv
// Bench for aes_in_seq. Two instances: A with default parameters (long
// timeout, 16-bit counter) and B with an 8-cycle timeout and 2-bit counter.
// Both see the same stimulus; 'sel' picks the instance being observed.
module tb_aes_in_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        tb_valid;
  logic [31:0] tb_data;
  logic        tb_kw, tb_mode, tb_kdone, tb_done;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  aes_in_seq_if bus_a ();
  aes_in_seq_if bus_b ();

  assign bus_a.in_valid = tb_valid;
  assign bus_a.in_data  = tb_data;
  assign bus_a.in_kw    = tb_kw;
  assign bus_a.in_mode  = tb_mode;
  assign bus_b.in_valid = tb_valid;
  assign bus_b.in_data  = tb_data;
  assign bus_b.in_kw    = tb_kw;
  assign bus_b.in_mode  = tb_mode;

  logic         kld_a, ld_a, mode_a, kv_a, busy_a, ep_a, en_a, et_a;
  logic [127:0] key_a, text_a;
  logic [15:0]  blk_a;
  logic         kld_b, ld_b, mode_b, kv_b, busy_b, ep_b, en_b, et_b;
  logic [127:0] key_b, text_b;
  logic [1:0]   blk_b;

  aes_in_seq dut_a (
    .clk(clk), .rst(rst), .in_if(bus_a),
    .kld(kld_a), .key(key_a), .ld(ld_a), .text_in(text_a), .mode(mode_a),
    .kdone(tb_kdone), .done(tb_done), .key_valid(kv_a), .busy(busy_a),
    .err_proto(ep_a), .err_nokey(en_a), .err_tmo(et_a), .blk_cnt(blk_a)
  );

  aes_in_seq #(.TMO_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_if(bus_b),
    .kld(kld_b), .key(key_b), .ld(ld_b), .text_in(text_b), .mode(mode_b),
    .kdone(tb_kdone), .done(tb_done), .key_valid(kv_b), .busy(busy_b),
    .err_proto(ep_b), .err_nokey(en_b), .err_tmo(et_b), .blk_cnt(blk_b)
  );

  wire         o_rdy  = sel ? bus_b.in_ready : bus_a.in_ready;
  wire         o_kld  = sel ? kld_b : kld_a;
  wire         o_ld   = sel ? ld_b : ld_a;
  wire         o_mode = sel ? mode_b : mode_a;
  wire         o_kv   = sel ? kv_b : kv_a;
  wire         o_busy = sel ? busy_b : busy_a;
  wire         o_ep   = sel ? ep_b : ep_a;
  wire         o_en   = sel ? en_b : en_a;
  wire         o_et   = sel ? et_b : et_a;
  wire [127:0] o_key  = sel ? key_b : key_a;
  wire [127:0] o_text = sel ? text_b : text_a;
  wire [15:0]  o_blk  = sel ? {14'd0, blk_b} : blk_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tb_valid = 1'b0; tb_kdone = 1'b0; tb_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Offer one word; returns just after the edge that accepted it.
  task automatic send_word(input logic [31:0] d, input logic kw, input logic md);
    int n;
    n = 0;
    tb_valid = 1'b1; tb_data = d; tb_kw = kw; tb_mode = md;
    while (!o_rdy && n < 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL send_word_ready: in_ready stuck at %0b, wanted 1 within 100 cycles", o_rdy);
    end
    step();
    tb_valid = 1'b0;
  endtask

  // Word 0 carries the real mode; later words carry noise that must be ignored.
  task automatic send_block(input logic [127:0] b, input logic kw, input logic md);
    send_word(b[127:96], kw, md);
    send_word(b[95:64], kw, 1'($urandom % 2));
    send_word(b[63:32], kw, 1'($urandom % 2));
    send_word(b[31:0], kw, 1'($urandom % 2));
  endtask

  // Called in the pulse cycle; raises the response in pulse cycle + lat.
  task automatic wait_resp(input int lat, input logic is_key);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == lat) begin
        if (is_key) tb_kdone = 1'b1;
        else tb_done = 1'b1;
      end
    end
    step();
    tb_kdone = 1'b0; tb_done = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k, input int lat);
    send_block(k, 1'b1, 1'b0);
    wait_resp(lat, 1'b1);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1; tb_valid = 1'b1; tb_data = 32'hdeadbeef; tb_kw = 1'b1; tb_mode = 1'b0;
    tb_kdone = 1'b0; tb_done = 1'b0;
    step();
    n_cmp++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %0b want 0", o_rdy);
    end
    step();
    n_cmp++;
    if ({o_kld, o_ld, o_mode, o_kv, o_busy, o_ep, o_en, o_et} !== 8'd0 || o_key !== '0 ||
        o_text !== '0 || o_blk !== 16'd0) begin
      n_err++; $display("FAIL reset_outputs: got flags %b key %h blk %0d want all 0",
                        {o_kld, o_ld, o_mode, o_kv, o_busy, o_ep, o_en, o_et}, o_key, o_blk);
    end
    tb_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %0b want 1", o_rdy);
    end
  endtask

  task automatic test_key_load();
    logic [127:0] k;
    logic         rdy_seen, kld_bad;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    sel = 1'b0;
    do_reset();
    send_block(k, 1'b1, 1'b0);
    n_cmp++;
    if (o_kld !== 1'b1 || o_key !== k || o_kv !== 1'b0 || o_rdy !== 1'b0) begin
      n_err++; $display("FAIL key_pulse: kld %0b key %h kv %0b rdy %0b want 1 %h 0 0",
                        o_kld, o_key, o_kv, o_rdy, k);
    end
    rdy_seen = 1'b0; kld_bad = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (o_kld !== 1'b0) kld_bad = 1'b1;
      if (o_rdy !== 1'b0) rdy_seen = 1'b1;
      if (c == 10) tb_kdone = 1'b1;
    end
    step();
    tb_kdone = 1'b0;
    n_cmp++;
    if (kld_bad !== 1'b0 || rdy_seen !== 1'b0) begin
      n_err++; $display("FAIL key_wait: kld_extra %0b ready_during_wait %0b want 0 0",
                        kld_bad, rdy_seen);
    end
    n_cmp++;
    if (o_rdy !== 1'b1 || o_kv !== 1'b1 || o_key !== k) begin
      n_err++; $display("FAIL key_done: rdy %0b kv %0b key %h want 1 1 %h", o_rdy, o_kv, o_key, k);
    end
  endtask

  // Continues from the key load above.
  task automatic test_text_encrypt();
    logic [127:0] t;
    logic         rdy_seen, ld_bad;
    t = 128'h00112233445566778899aabbccddeeff;
    sel = 1'b0;
    send_block(t, 1'b0, 1'b0);
    n_cmp++;
    if (o_ld !== 1'b1 || o_text !== t || o_mode !== 1'b0 || o_blk !== 16'd0) begin
      n_err++; $display("FAIL text_pulse: ld %0b text %h mode %0b blk %0d want 1 %h 0 0",
                        o_ld, o_text, o_mode, o_blk, t);
    end
    rdy_seen = 1'b0; ld_bad = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (o_ld !== 1'b0) ld_bad = 1'b1;
      if (o_rdy !== 1'b0) rdy_seen = 1'b1;
      if (c == 3) tb_done = 1'b1;
    end
    step();
    tb_done = 1'b0;
    n_cmp++;
    if (ld_bad !== 1'b0 || rdy_seen !== 1'b0) begin
      n_err++; $display("FAIL text_wait: ld_extra %0b ready_during_wait %0b want 0 0",
                        ld_bad, rdy_seen);
    end
    n_cmp++;
    if (o_blk !== 16'd1 || o_rdy !== 1'b1) begin
      n_err++; $display("FAIL text_done: blk %0d rdy %0b want 1 1", o_blk, o_rdy);
    end
  endtask

  task automatic test_no_key();
    sel = 1'b0;
    do_reset();
    send_block(128'hffeeddccbbaa99887766554433221100, 1'b0, 1'b1);
    n_cmp++;
    if (o_en !== 1'b1 || o_ld !== 1'b0 || o_rdy !== 1'b1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL nokey_pulse: en %0b ld %0b rdy %0b busy %0b want 1 0 1 0",
                        o_en, o_ld, o_rdy, o_busy);
    end
    step();
    n_cmp++;
    if (o_en !== 1'b0 || o_ld !== 1'b0 || o_blk !== 16'd0) begin
      n_err++; $display("FAIL nokey_after: en %0b ld %0b blk %0d want 0 0 0", o_en, o_ld, o_blk);
    end
  endtask

  task automatic test_proto();
    logic [127:0] t;
    t = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    sel = 1'b0;
    do_reset();
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 3);
    send_word(32'h11111111, 1'b0, 1'b0);
    send_word(32'h22222222, 1'b1, 1'b0);
    n_cmp++;
    if (o_ep !== 1'b1) begin
      n_err++; $display("FAIL proto_pulse: got %0b want 1", o_ep);
    end
    step();
    n_cmp++;
    if (o_ep !== 1'b0) begin
      n_err++; $display("FAIL proto_width: got %0b want 0", o_ep);
    end
    send_block(t, 1'b0, 1'b1);
    n_cmp++;
    if (o_ld !== 1'b1 || o_text !== t || o_mode !== 1'b1) begin
      n_err++; $display("FAIL proto_recover: ld %0b text %h mode %0b want 1 %h 1",
                        o_ld, o_text, o_mode, t);
    end
    wait_resp(2, 1'b0);
  endtask

  task automatic test_timeout();
    logic et_early, busy_low;
    sel = 1'b1;
    do_reset();
    load_key(128'h0123456789abcdef0123456789abcdef, 2);
    send_block(128'h1, 1'b0, 1'b0);
    et_early = 1'b0; busy_low = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c < 9) begin
        if (o_et !== 1'b0) et_early = 1'b1;
        if (o_busy !== 1'b1) busy_low = 1'b1;
      end
    end
    n_cmp++;
    if (et_early !== 1'b0 || busy_low !== 1'b0) begin
      n_err++; $display("FAIL tmo_wait: early_err %0b busy_dropped %0b want 0 0", et_early, busy_low);
    end
    n_cmp++;
    if (o_et !== 1'b1 || o_kv !== 1'b0 || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
      n_err++; $display("FAIL tmo_pulse: et %0b kv %0b busy %0b rdy %0b want 1 0 0 1",
                        o_et, o_kv, o_busy, o_rdy);
    end
    step();
    n_cmp++;
    if (o_et !== 1'b0 || o_blk !== 16'd0) begin
      n_err++; $display("FAIL tmo_width: et %0b blk %0d want 0 0", o_et, o_blk);
    end
    load_key(128'h0123456789abcdef0123456789abcdef, 2);
    send_block(128'h2, 1'b0, 1'b0);
    wait_resp(8, 1'b0);
    n_cmp++;
    if (o_blk !== 16'd1 || o_et !== 1'b0 || o_kv !== 1'b1) begin
      n_err++; $display("FAIL tmo_last_cycle_done: blk %0d et %0b kv %0b want 1 0 1",
                        o_blk, o_et, o_kv);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k2;
    k2 = 128'hcafef00dcafef00dcafef00dcafef00d;
    sel = 1'b0;
    do_reset();
    load_key(128'h5555aaaa5555aaaa5555aaaa5555aaaa, 2);
    send_block(128'h77777777777777777777777777777777, 1'b0, 1'b1);
    wait_resp(2, 1'b0);
    send_word(32'h99999999, 1'b0, 1'b0);
    send_word(32'h88888888, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    n_cmp++;
    if ({o_kld, o_ld, o_mode, o_kv, o_busy, o_ep, o_en, o_et} !== 8'd0 || o_key !== '0 ||
        o_text !== '0 || o_blk !== 16'd0 || o_rdy !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs: flags %b key %h text %h blk %0d rdy %0b want 0",
                        {o_kld, o_ld, o_mode, o_kv, o_busy, o_ep, o_en, o_et},
                        o_key, o_text, o_blk, o_rdy);
    end
    rst = 1'b0;
    #1;
    send_block(k2, 1'b1, 1'b0);
    n_cmp++;
    if (o_kld !== 1'b1 || o_key !== k2 || o_ep !== 1'b0) begin
      n_err++; $display("FAIL midreset_word0: kld %0b key %h ep %0b want 1 %h 0",
                        o_kld, o_key, o_ep, k2);
    end
    wait_resp(2, 1'b1);
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    do_reset();
    load_key(128'h3, 1);
    for (int b = 0; b < 5; b++) begin
      send_block(128'(b + 16), 1'b0, 1'b0);
      wait_resp(1 + b, 1'b0);
      n_cmp++;
      if (o_blk !== 16'((b + 1) % 4)) begin
        n_err++; $display("FAIL wrap_blk%0d: got %0d want %0d", b, o_blk, (b + 1) % 4);
      end
    end
  endtask

  // Random key/text blocks with random core latency, stray responses and
  // occasional mid-block type switches, against a block-level model.
  task automatic test_random();
    logic [127:0] m_key, m_text, b;
    logic         m_kv, m_mode, kw, md, bad, exp_et;
    logic [2:0]   exp_p;
    int           m_blk, lat;
    sel = 1'b1;
    do_reset();
    m_key = '0; m_text = '0; m_kv = 1'b0; m_mode = 1'b0; m_blk = 0;
    for (int i = 0; i < 40; i++) begin
      kw  = 1'($urandom % 2);
      md  = 1'($urandom % 2);
      b   = {$urandom, $urandom, $urandom, $urandom};
      lat = 1 + int'($urandom % 10);
      if ($urandom % 5 == 0) begin
        send_word($urandom, kw, md);
        send_word($urandom, !kw, md);
        n_cmp++;
        if (o_ep !== 1'b1) begin
          n_err++; $display("FAIL rnd_proto%0d: got %0b want 1", i, o_ep);
        end
      end
      send_block(b, kw, md);
      if (kw) begin
        exp_p = 3'b100; m_key = b; m_kv = 1'b0;
      end else if (m_kv) begin
        exp_p = 3'b010; m_text = b; m_mode = md;
      end else begin
        exp_p = 3'b001;
      end
      n_cmp++;
      if ({o_kld, o_ld, o_en} !== exp_p) begin
        n_err++; $display("FAIL rnd_pulse%0d: kld/ld/nokey %b want %b", i, {o_kld, o_ld, o_en}, exp_p);
      end
      n_cmp++;
      if (o_key !== m_key || o_text !== m_text || o_mode !== m_mode || o_kv !== m_kv) begin
        n_err++; $display("FAIL rnd_regs%0d: key %h text %h mode %0b kv %0b want %h %h %0b %0b",
                          i, o_key, o_text, o_mode, o_kv, m_key, m_text, m_mode, m_kv);
      end
      if (exp_p == 3'b001) continue;
      // Responses in the pulse cycle itself must be ignored.
      tb_kdone = 1'($urandom % 2);
      tb_done  = 1'($urandom % 2);
      bad = 1'b0;
      for (int c = 1; c <= lat && c <= 8; c++) begin
        step();
        if (o_et !== 1'b0 || o_busy !== 1'b1 || o_rdy !== 1'b0) bad = 1'b1;
        if (kw) begin
          tb_kdone = (c == lat); tb_done = 1'($urandom % 2);
        end else begin
          tb_done = (c == lat); tb_kdone = 1'($urandom % 2);
        end
      end
      step();
      tb_kdone = 1'b0; tb_done = 1'b0;
      if (lat <= 8) begin
        if (kw) m_kv = 1'b1;
        else m_blk = (m_blk + 1) % 4;
        exp_et = 1'b0;
      end else begin
        m_kv = 1'b0;
        exp_et = 1'b1;
      end
      n_cmp++;
      if (bad !== 1'b0) begin
        n_err++; $display("FAIL rnd_wait%0d: early exit or error during wait, want none", i);
      end
      n_cmp++;
      if ({o_et, o_busy, o_rdy} !== {exp_et, 2'b01} || o_kv !== m_kv ||
          o_blk !== 16'(m_blk) || o_key !== m_key || o_text !== m_text) begin
        n_err++; $display("FAIL rnd_end%0d: et/busy/rdy %b kv %0b blk %0d want %b %0b %0d",
                          i, {o_et, o_busy, o_rdy}, o_kv, o_blk, {exp_et, 2'b01}, m_kv, m_blk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst = 1'b1; tb_valid = 1'b0; tb_data = '0; tb_kw = 1'b0; tb_mode = 1'b0;
    tb_kdone = 1'b0; tb_done = 1'b0;
    test_reset();
    test_key_load();
    test_text_encrypt();
    test_no_key();
    test_proto();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
